// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU definitions for the register-file write-back path.
package rf_wb_arbiter_pkg;
  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // Requester indices into req_valid / req_ready
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  // Pointer width for an N-way arbiter (at least one bit)
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant, registered search pointer.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int PW = ptr_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr;
  logic          hit;
  int            idx;

  // First valid requester at or after ptr, wrapping; nothing granted in reset
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!hit && !rst && req[idx]) begin
        hit       = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  // Pointer moves just past the winner; holds when idle
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (hit)
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin select among result producers, one-cycle
// registered RF write port, and a pending-write scoreboard for issue checks.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  input  logic [AW-1:0]    chk_addr1,
  input  logic [AW-1:0]    chk_addr2,
  output logic             busy1,
  output logic             busy2,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data
);

  localparam int PW   = ptr_w(NREQ);
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   grant_idx;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] pending, set_vec, clr_vec;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  // Grants only go to valid requesters, so any grant is a transfer
  always_comb begin
    xfer     = |req_ready;
    sel_addr = req_addr[int'(grant_idx)*AW +: AW];
    sel_data = req_data[int'(grant_idx)*DW +: DW];
  end

  // Register the winner; r0 transfers are consumed but never written,
  // and the port holds its last address/data whenever wr_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer && sel_addr != '0) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Scoreboard set/clear vectors; r0 is never tracked
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_addr != '0) set_vec[issue_addr] = 1'b1;
    if (wr_en) clr_vec[wr_addr] = 1'b1;
  end

  // Set is applied after clear so a same-edge issue keeps the bit pending
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

  // No bypass of the in-flight write: the RF shows it next cycle
  always_comb begin
    busy1 = (chk_addr1 != '0) && pending[chk_addr1];
    busy2 = (chk_addr2 != '0) && pending[chk_addr2];
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic against a cycle-level reference model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  logic              clk, rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr, chk_addr1, chk_addr2;
  logic              busy1, busy2, wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  int errors, checks;

  // reference model state
  int          m_ptr;
  bit          m_pend [NREG];
  bit          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    return (a != 0) && m_pend[a];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid = '0; issue_valid = 1'b0; issue_addr = '0;
  endtask

  // Advance model by one edge using the inputs currently driven, then clock DUT
  task automatic tick();
    int g;
    logic [AW-1:0] a;
    g = model_grant();
    if (rst) begin
      m_ptr = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    end else begin
      if (m_wr_en) m_pend[m_wr_addr] = 0;
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
      m_wr_en = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        a = req_addr[g*AW +: AW];
        if (a != 0) begin
          m_wr_en = 1; m_wr_addr = a; m_wr_data = req_data[g*DW +: DW];
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; issue_valid = 1'b1; issue_addr = 5'd9; chk_addr1 = 5'd9;
    req_addr = '1; req_data = '1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    tick(); tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL reset_wr_port: got %h/%h want 0/0", wr_addr, wr_data); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    rst = 1'b0; idle(); req_addr = '0; req_data = '0; chk_addr1 = '0; chk_addr2 = '0;
  endtask

  task automatic test_order();
    logic [NREQ-1:0] exp;
    set_req(0, 1, 5'd1, 32'h11); set_req(1, 1, 5'd2, 32'h22); set_req(2, 1, 5'd3, 32'h33);
    for (int k = 0; k < 3; k++) begin
      #1;
      exp = '0; exp[k] = 1'b1;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL order_grant%0d: got %b want %b", k, req_ready, exp); end
      tick();
      req_valid[k] = 1'b0;
      checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(k+1) || wr_data !== DW'(32'h11*(k+1)))
        begin errors++; $display("FAIL order_write%0d: got %b/%h/%h want 1/%h/%h", k, wr_en, wr_addr, wr_data, k+1, 32'h11*(k+1)); end
    end
    tick();
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd3 || wr_data !== 32'h33)
      begin errors++; $display("FAIL order_hold: got %b/%h/%h want 0/3/33", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_single();
    for (int k = 0; k < 3; k++) begin
      set_req(2, 1, AW'(10+k), DW'(32'hA0+k));
      #1;
      checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL single_grant%0d: got %b want 100", k, req_ready); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(10+k) || wr_data !== DW'(32'hA0+k))
        begin errors++; $display("FAIL single_write%0d: got %b/%h/%h want 1/%h/%h", k, wr_en, wr_addr, wr_data, 10+k, 32'hA0+k); end
    end
    req_valid = '1; #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ptr0: got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_busy();
    issue_valid = 1'b1; issue_addr = 5'd5; chk_addr1 = 5'd5;
    tick();
    issue_valid = 1'b0; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_set: got %b want 1", busy1); end
    tick(); tick();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b want 1", busy1); end
    set_req(0, 1, 5'd5, 32'h5555); #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_xfer: got %b want 1", busy1); end
    tick(); req_valid = '0; #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || busy1 !== 1'b1)
      begin errors++; $display("FAIL busy_nobypass: got wr %b/%h busy %b want 1/5 busy 1", wr_en, wr_addr, busy1); end
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b want 0", busy1); end
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1; issue_addr = 5'd7; tick();
    issue_valid = 1'b0;
    set_req(1, 1, 5'd7, 32'h7777); tick(); req_valid = '0;
    issue_valid = 1'b1; issue_addr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd0; #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin errors++; $display("FAIL setwin_wr: got %b/%h want 1/7", wr_en, wr_addr); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL setwin_r0a: got %b want 0", busy2); end
    tick(); issue_valid = 1'b0; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL setwin_keep: got %b want 1", busy1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL setwin_r0b: got %b want 0", busy2); end
  endtask

  task automatic test_addr_zero();
    do_reset();
    set_req(0, 1, 5'd9, 32'h99); tick(); req_valid = '0;
    set_req(1, 1, 5'd0, 32'hDEADBEEF); #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL r0_grant: got %b want 010", req_ready); end
    tick(); req_valid = '0;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd9 || wr_data !== 32'h99)
      begin errors++; $display("FAIL r0_nowrite: got %b/%h/%h want 0/9/99", wr_en, wr_addr, wr_data); end
    req_valid = '1; #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL r0_ptr2: got %b want 100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_addr = 5'd3; chk_addr1 = 5'd3; tick(); issue_valid = 1'b0;
    set_req(0, 1, 5'd4, 32'h1); set_req(1, 1, 5'd6, 32'h2); set_req(2, 1, 5'd8, 32'h3);
    tick();  // grant in flight, ptr advanced
    rst = 1'b1; #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", req_ready); end
    tick(); rst = 1'b0; #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", wr_en); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_grant0: got %b want 001", req_ready); end
    tick(); req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i])
          set_req(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), DW'($urandom));
      issue_valid = $urandom_range(0, 1);
      issue_addr  = AW'($urandom_range(0, 7));
      chk_addr1   = AW'($urandom_range(0, 7));
      chk_addr2   = AW'($urandom_range(0, 7));
      #1;
      g = model_grant();
      checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, req_ready, onehot(g)); end
      checks++; if (busy1 !== model_busy(chk_addr1) || busy2 !== model_busy(chk_addr2))
        begin errors++; $display("FAIL rnd_busy@%0d: got %b%b want %b%b", n, busy1, busy2, model_busy(chk_addr1), model_busy(chk_addr2)); end
      tick();
      checks++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data)
        begin errors++; $display("FAIL rnd_wr@%0d: got %b/%h/%h want %b/%h/%h", n, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data); end
      if (g >= 0) req_valid[g] = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    m_ptr = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    @(posedge clk); #1;
    test_reset();
    test_order();
    test_single();
    test_busy();
    test_set_wins();
    test_addr_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
